// File: rtl/br_ram_rd_initiator_resp_buf.sv
// ----------------------------------------------------------------------------
// br_ram_rd_initiator_resp_buf
//
// Circular flop buffer that captures RAM read data and hands it out in order.
// A capture writes at the write pointer and is visible the next cycle. A pop
// advances the read pointer. Capture and pop in the same cycle leave the
// occupancy unchanged.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   cap_valid_i  capture strobe (RAM read data valid)
//   cap_data_i   data to capture
//   pop_ready_i  consumer ready
//   pop_valid_o  buffer holds at least one entry
//   pop_data_o   entry at the read pointer
//   occupancy_o  number of entries held
//   full_o       occupancy equals Entries
// ----------------------------------------------------------------------------
module br_ram_rd_initiator_resp_buf #(
  parameter int Width   = 8,
  parameter int Entries = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cap_valid_i,
  input  logic [Width-1:0]                 cap_data_i,
  input  logic                             pop_ready_i,
  output logic                             pop_valid_o,
  output logic [Width-1:0]                 pop_data_o,
  output logic [$clog2(Entries+1)-1:0]     occupancy_o,
  output logic                             full_o
);

  // A single-entry buffer still needs a 1-bit pointer to keep widths legal.
  localparam int PtrW = (Entries > 1) ? $clog2(Entries) : 1;
  localparam int CntW = $clog2(Entries + 1);

  logic [Width-1:0] mem_q [Entries];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  occ_q, occ_d;
  logic             pop_hs;

  // Pointers wrap at Entries-1, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    if (p == PtrW'(Entries - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  assign pop_valid_o = (occ_q != '0);
  assign pop_data_o  = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;
  assign full_o      = (occ_q == CntW'(Entries));
  assign pop_hs      = pop_valid_o && pop_ready_i;

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (cap_valid_i) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_hs)      rd_ptr_d = next_ptr(rd_ptr_q);
    unique case ({cap_valid_i, pop_hs})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: the storage array is reset because pop_data must read 0 out of
  // reset; this is a handful of flops, not a RAM macro, so the cost is small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) mem_q[i] <= '0;
    end else if (cap_valid_i) begin
      mem_q[wr_ptr_q] <= cap_data_i;
    end
  end

endmodule

// File: rtl/br_ram_rd_initiator.sv
// ----------------------------------------------------------------------------
// br_ram_rd_initiator
//
// Read-side initiator for a fixed-latency 1R1W flop RAM. Read requests are
// accepted on a valid/ready push interface and forwarded combinationally to
// the RAM read port. Returning data is captured in a response buffer and
// presented in request order on a valid/ready pop interface. A credit counter
// reserves a buffer entry for every issued read, so RAM data is never dropped
// and never has to be stalled.
//
// Parameters: Depth (RAM entries, >= 2), Width (>= 1), ReadLatency (>= 0),
// RespBufferDepth (>= 1; >= ReadLatency+2 for one request per cycle).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_valid/ready/addr   read request handshake
//   rd_addr_valid/rd_addr   RAM read strobe and address
//   rd_data_valid/rd_data   RAM read return
//   pop_valid/ready/data    response handshake
//   credit_count            unreserved response buffer entries
// ----------------------------------------------------------------------------
module br_ram_rd_initiator #(
  parameter int Depth           = 16,
  parameter int Width           = 8,
  parameter int ReadLatency     = 1,
  parameter int RespBufferDepth = 3
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     push_valid,
  output logic                                     push_ready,
  input  logic [$clog2(Depth)-1:0]                 push_addr,
  output logic                                     rd_addr_valid,
  output logic [$clog2(Depth)-1:0]                 rd_addr,
  input  logic                                     rd_data_valid,
  input  logic [Width-1:0]                         rd_data,
  output logic                                     pop_valid,
  input  logic                                     pop_ready,
  output logic [Width-1:0]                         pop_data,
  output logic [$clog2(RespBufferDepth+1)-1:0]     credit_count
);

  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = $clog2(RespBufferDepth + 1);

  logic [CntW-1:0]  credit_q, credit_d;
  logic [AddrW-1:0] rd_addr_q, rd_addr_d;
  logic [CntW-1:0]  occupancy;
  logic             buf_full;
  logic             push_hs;
  logic             pop_hs;

  // Ready depends only on the registered credit, never on pop_ready, so a pop
  // frees its credit one cycle later and there is no combinational loop.
  assign push_ready = !rst && (credit_q != '0);
  assign push_hs    = push_valid && push_ready;
  assign pop_hs     = pop_valid && pop_ready;

  always_comb begin
    credit_d  = credit_q;
    rd_addr_d = rd_addr_q;
    unique case ({push_hs, pop_hs})
      2'b10:   credit_d = credit_q - CntW'(1);
      2'b01:   credit_d = credit_q + CntW'(1);
      default: credit_d = credit_q;
    endcase
    if (push_hs) rd_addr_d = push_addr;
  end

  // The address is forwarded in the push cycle and then held, so rd_addr is
  // stable between requests.
  assign rd_addr_valid = push_hs;
  assign rd_addr       = rd_addr_d;
  assign credit_count  = credit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q  <= CntW'(RespBufferDepth);
      rd_addr_q <= '0;
    end else begin
      credit_q  <= credit_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  br_ram_rd_initiator_resp_buf #(
    .Width   (Width),
    .Entries (RespBufferDepth)
  ) u_resp_buf (
    .clk         (clk),
    .rst         (rst),
    .cap_valid_i (rd_data_valid),
    .cap_data_i  (rd_data),
    .pop_ready_i (pop_ready),
    .pop_valid_o (pop_valid),
    .pop_data_o  (pop_data),
    .occupancy_o (occupancy),
    .full_o      (buf_full)
  );

  // In-flight reads = RespBufferDepth - credit - occupancy; none are in flight
  // when credit and occupancy together account for the whole buffer.
  logic [CntW:0] reserved_sum;
  logic          no_inflight;
  assign reserved_sum = {1'b0, credit_q} + {1'b0, occupancy};
  assign no_inflight  = (reserved_sum == (CntW+1)'(RespBufferDepth));

  // With zero latency the RAM answers the push of the same cycle, before the
  // credit register has counted it.
  a_no_orphan_data : assert property (@(posedge clk) disable iff (rst)
    rd_data_valid |-> (!no_inflight || (ReadLatency == 0 && push_hs)));

  a_no_capture_full : assert property (@(posedge clk) disable iff (rst)
    rd_data_valid |-> !buf_full);

  a_push_stable : assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> (push_valid && $stable(push_addr)));

endmodule
